stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control FSM that sequences the centisecond/second/minute counter chain as a stopwatch. Synchronizes three push-buttons (start/stop, lap, clear) and generates the 100 Hz count-enable pulse from the system clock. Drives the chain's enable and synchronous clear inputs, plus a display-hold flag for lap (split) time. Sits between the button inputs and the counter chain; its outputs are the chain's ena and res inputs.

Parameters:
CLK_HZ, 1000000, system clock frequency in Hz.
TICK_HZ, 100, count-enable rate in Hz. CLK_HZ/TICK_HZ must be an integer ≥2. DIV = CLK_HZ/TICK_HZ.
LOCKOUT_TICKS, 5, number of ticks during which a button ignores further edges after an accepted press.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_start  in  1  start/stop button, asynchronous, active-high
btn_lap  in  1  lap button, asynchronous, active-high
btn_clear  in  1  clear button, asynchronous, active-high
at_max  in  1  chain reads 59:59.99 (decoded externally from chain digits)
chain_ena  out  1  one-cycle count pulse to the chain's ena input
chain_res  out  1  synchronous clear to the chain's res input
disp_hold  out  1  display must freeze its latched digits while 1
state  out  2  IDLE=00, RUNNING=01, PAUSED=10, LAP=11

Behaviour:
- Reset (rst_n=0, async): state=IDLE, chain_ena=0, chain_res=1, disp_hold=0, prescaler=0, synchronizers=0, lockouts cleared. chain_res deasserts on the first clk edge after rst_n rises.
- Inputs: each button passes through a 2-FF synchronizer followed by a rising-edge detect. Press pulse = synchronized 0→1 transition while that button's lockout counter is 0. An accepted press loads the lockout with LOCKOUT_TICKS. The lockout decrements on each tick while the prescaler runs. Outside RUNNING/LAP, it decrements on free-running prescaler wraps, so the lockout always expires. Press-to-FSM latency is 3 clk cycles.
- Prescaler: counts 0..DIV-1 continuously in all states. tick = (count==DIV-1).
  - On an IDLE→RUNNING transition, the prescaler is zeroed, so the first chain_ena comes exactly DIV cycles later.
  - PAUSED→RUNNING does not zero it. A resume loses at most one partial period; this is accepted.
- chain_ena = tick & (state∈{RUNNING,LAP}) & !at_max. It is registered, so it is high for exactly one cycle.
- Simultaneous presses in the same cycle have priority clear > start > lap. Only the highest-priority press acts; the others are discarded, but their lockouts are still loaded.
- Transitions:
  - IDLE: start→RUNNING. lap and clear are ignored.
  - RUNNING: start→PAUSED. lap→LAP (disp_hold=1 next cycle). clear is ignored.
  - LAP: start→PAUSED (disp_hold=0). lap→RUNNING (disp_hold=0; the display resumes showing the live count). clear is ignored. The chain keeps counting in LAP.
  - PAUSED: start→RUNNING. clear→IDLE with chain_res=1 for exactly one cycle. lap is ignored.
  - RUNNING or LAP with tick & at_max: go to PAUSED, emit no chain_ena, set disp_hold=0. The chain holds at 59:59.99. No wrap-around is ever produced.
- disp_hold=1 iff state==LAP (registered with state).
- chain_res and chain_ena are never high in the same cycle.
- state output equals the internal state register.

Test Plan:
(CLK_HZ=1000, TICK_HZ=100, so DIV=10; LOCKOUT_TICKS=2)
1. Reset and start: release rst_n → chain_res high, then low after one edge; state=00. Pulse btn_start → state=01 after 3 cycles. chain_ena pulses every 10 cycles, first pulse 10 cycles after the transition. 25 pulses counted in 250 cycles.
2. Pause/resume/clear:
   - While RUNNING, press start → state=10, chain_ena stays 0 for 100 cycles.
   - Press clear → one-cycle chain_res, state=00.
   - Press clear in RUNNING → ignored, no chain_res.
3. Lap: RUNNING, press lap → state=11, disp_hold=1, chain_ena continues every 10 cycles. Press lap again → state=01, disp_hold=0. In LAP, press start → state=10, disp_hold=0.
4. Lockout/bounce: toggle btn_start 0/1 every 2 cycles for 20 cycles → exactly one transition (IDLE→RUNNING). A clean press 30 cycles later is accepted → PAUSED.
5. Priority: assert btn_start and btn_clear in the same cycle while PAUSED → state=00 with a chain_res pulse, and no RUNNING.
6. Saturation: in RUNNING, hold at_max=1 → no chain_ena at the next tick, state=10, disp_hold=0. Same from LAP.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: synchronises the start/stop, lap and clear buttons, derives the
// count-enable tick from the system clock and sequences a mm:ss.cc counter chain
// through idle, running, paused and lap (split display) modes.
module stopwatch_ctrl #(
    parameter int CLK_HZ        = 1000000,
    parameter int TICK_HZ       = 100,
    parameter int LOCKOUT_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    input  logic       at_max,
    output logic       chain_ena,
    output logic       chain_res,
    output logic       disp_hold,
    output logic [1:0] state
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam int LO_W  = (LOCKOUT_TICKS > 0) ? $clog2(LOCKOUT_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
    localparam logic [LO_W-1:0]  LO_LOAD = LO_W'(LOCKOUT_TICKS);

    // Button bit positions inside the packed button vectors
    localparam int B_START = 0;
    localparam int B_LAP   = 1;
    localparam int B_CLEAR = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUNNING = 2'b01,
        S_PAUSED  = 2'b10,
        S_LAP     = 2'b11
    } state_t;

    logic [2:0]       btn_raw;
    logic [2:0]       sync1_q, sync2_q, prev_q;
    logic [2:0]       press;
    logic [LO_W-1:0]  lock_q [3];
    logic [LO_W-1:0]  lock_d [3];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;
    logic             sat;
    logic             sel_start, sel_lap, sel_clear;
    state_t           state_q, state_d;
    logic             ena_q, ena_d;
    logic             res_q, res_d;
    logic             hold_q;

    assign btn_raw = {btn_clear, btn_lap, btn_start};
    assign tick    = (cnt_q == CNT_MAX);
    assign sat     = tick & at_max;

    // Two-flop synchroniser per button, plus one delay flop for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Press pulses gated by lockout; an accepted press reloads its lockout, ticks drain it
    always_comb begin
        press = '0;
        for (int i = 0; i < 3; i++) begin
            press[i]  = sync2_q[i] & ~prev_q[i] & (lock_q[i] == '0);
            lock_d[i] = lock_q[i];
            if (press[i]) begin
                lock_d[i] = LO_LOAD;
            end else if (tick && (lock_q[i] != '0)) begin
                lock_d[i] = lock_q[i] - 1'b1;
            end
        end
    end

    // Lockout counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) lock_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) lock_q[i] <= lock_d[i];
        end
    end

    // Only the highest-priority press of a cycle reaches the FSM: clear > start > lap
    assign sel_clear = press[B_CLEAR];
    assign sel_start = press[B_START] & ~press[B_CLEAR];
    assign sel_lap   = press[B_LAP] & ~press[B_START] & ~press[B_CLEAR];

    // Next state, chain strobes and prescaler next value
    always_comb begin
        state_d = state_q;
        res_d   = 1'b0;
        ena_d   = tick & ((state_q == S_RUNNING) || (state_q == S_LAP)) & ~at_max;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                if (sel_start) state_d = S_RUNNING;
            end
            S_RUNNING: begin
                if (sat)            state_d = S_PAUSED;
                else if (sel_start) state_d = S_PAUSED;
                else if (sel_lap)   state_d = S_LAP;
            end
            S_LAP: begin
                if (sat)            state_d = S_PAUSED;
                else if (sel_start) state_d = S_PAUSED;
                else if (sel_lap)   state_d = S_RUNNING;
            end
            S_PAUSED: begin
                if (sel_clear) begin
                    state_d = S_IDLE;
                    res_d   = 1'b1;
                end else if (sel_start) begin
                    state_d = S_RUNNING;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A fresh start restarts the period so the first count lands a full period later
        if ((state_q == S_IDLE) && (state_d == S_RUNNING)) cnt_d = '0;
    end

    // State, prescaler and registered outputs; chain clear is held during reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ena_q   <= 1'b0;
            res_q   <= 1'b1;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ena_q   <= ena_d;
            res_q   <= res_d;
            hold_q  <= (state_d == S_LAP);
        end
    end

    assign chain_ena = ena_q;
    assign chain_res = res_q;
    assign disp_hold = hold_q;
    assign state     = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DIV=10 and a 2-tick button lockout.
module tb_stopwatch_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_start;
    logic       btn_lap;
    logic       btn_clear;
    logic       at_max;
    logic       chain_ena;
    logic       chain_res;
    logic       disp_hold;
    logic [1:0] state;

    int cyc      = 0;
    int n_checks = 0;
    int n_err    = 0;

    // Scoreboard entry: expected outputs at a given cycle after a press
    typedef struct packed {
        int         due;
        logic [1:0] st;
        logic       hold;
        logic       res;
        int         id;
    } exp_t;

    // Table vector: buttons {clear,lap,start} and the expected result
    typedef struct packed {
        logic [2:0] btn;
        logic [1:0] st;
        logic       hold;
        logic       res;
    } vec_t;

    exp_t sb[$];
    vec_t vecs [12];

    stopwatch_ctrl #(
        .CLK_HZ(1000),
        .TICK_HZ(100),
        .LOCKOUT_TICKS(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_start(btn_start),
        .btn_lap(btn_lap),
        .btn_clear(btn_clear),
        .at_max(at_max),
        .chain_ena(chain_ena),
        .chain_res(chain_res),
        .disp_hold(disp_hold),
        .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Advance to the next falling edge, check invariants and due scoreboard entries
    task automatic step();
        exp_t e;
        @(negedge clk);
        check("ena_res_exclusive", int'(chain_ena & chain_res), 0);
        check("hold_iff_lap", int'(disp_hold), int'(state == 2'b11));
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check($sformatf("due_cycle_v%0d", e.id), cyc, e.due);
            check($sformatf("state_v%0d", e.id), int'(state), int'(e.st));
            check($sformatf("hold_v%0d", e.id), int'(disp_hold), int'(e.hold));
            check($sformatf("res_v%0d", e.id), int'(chain_res), int'(e.res));
        end
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One-cycle button pulse; outcome expected three edges later
    task automatic press(input logic [2:0] m, input logic [1:0] st, input logic hold,
                         input logic res, input int id);
        exp_t e;
        {btn_clear, btn_lap, btn_start} = m;
        e.due  = cyc + 3;
        e.st   = st;
        e.hold = hold;
        e.res  = res;
        e.id   = id;
        sb.push_back(e);
        step();
        {btn_clear, btn_lap, btn_start} = 3'b000;
        step();
        step();
    endtask

    task automatic count_ena(input int n, output int cnt, output int first);
        cnt   = 0;
        first = -1;
        for (int i = 0; i < n; i++) begin
            step();
            if (chain_ena) begin
                cnt++;
                if (first < 0) first = cyc;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n_ena;
        int first_ena;
        int changes;
        logic [1:0] last_st;

        rst_n = 1'b0;
        btn_start = 1'b0;
        btn_lap = 1'b0;
        btn_clear = 1'b0;
        at_max = 1'b0;

        vecs[0]  = '{btn: 3'b001, st: 2'b01, hold: 1'b0, res: 1'b0};
        vecs[1]  = '{btn: 3'b100, st: 2'b01, hold: 1'b0, res: 1'b0};
        vecs[2]  = '{btn: 3'b010, st: 2'b11, hold: 1'b1, res: 1'b0};
        vecs[3]  = '{btn: 3'b010, st: 2'b01, hold: 1'b0, res: 1'b0};
        vecs[4]  = '{btn: 3'b010, st: 2'b11, hold: 1'b1, res: 1'b0};
        vecs[5]  = '{btn: 3'b001, st: 2'b10, hold: 1'b0, res: 1'b0};
        vecs[6]  = '{btn: 3'b010, st: 2'b10, hold: 1'b0, res: 1'b0};
        vecs[7]  = '{btn: 3'b001, st: 2'b01, hold: 1'b0, res: 1'b0};
        vecs[8]  = '{btn: 3'b001, st: 2'b10, hold: 1'b0, res: 1'b0};
        vecs[9]  = '{btn: 3'b101, st: 2'b00, hold: 1'b0, res: 1'b1};
        vecs[10] = '{btn: 3'b010, st: 2'b00, hold: 1'b0, res: 1'b0};
        vecs[11] = '{btn: 3'b100, st: 2'b00, hold: 1'b0, res: 1'b0};

        // Reset values and release
        wait_cycles(3);
        check("rst_state", int'(state), 0);
        check("rst_ena", int'(chain_ena), 0);
        check("rst_res", int'(chain_res), 1);
        check("rst_hold", int'(disp_hold), 0);
        rst_n = 1'b1;
        #1;
        check("res_held_after_release", int'(chain_res), 1);
        step();
        check("res_drops_first_edge", int'(chain_res), 0);
        check("idle_after_release", int'(state), 0);

        // Start, then count-enable cadence
        press(3'b001, 2'b01, 1'b0, 1'b0, 1);
        t0 = cyc;
        count_ena(250, n_ena, first_ena);
        check("ena_count_250", n_ena, 25);
        check("ena_first_cycle", first_ena, t0 + 10);

        // Pause holds the chain, then clear from pause
        press(3'b001, 2'b10, 1'b0, 1'b0, 2);
        count_ena(100, n_ena, first_ena);
        check("ena_count_paused", n_ena, 0);
        press(3'b100, 2'b00, 1'b0, 1'b1, 3);
        step();
        check("res_one_cycle", int'(chain_res), 0);

        // Table of single presses across all states
        for (int i = 0; i < 12; i++) begin
            wait_cycles(25);
            press(vecs[i].btn, vecs[i].st, vecs[i].hold, vecs[i].res, 100 + i);
        end

        // Chain keeps counting in LAP
        wait_cycles(25);
        press(3'b001, 2'b01, 1'b0, 1'b0, 20);
        wait_cycles(25);
        press(3'b010, 2'b11, 1'b1, 1'b0, 21);
        count_ena(50, n_ena, first_ena);
        check("ena_count_lap", n_ena, 5);

        // Saturation from LAP
        at_max = 1'b1;
        count_ena(15, n_ena, first_ena);
        check("sat_lap_no_ena", n_ena, 0);
        check("sat_lap_state", int'(state), 2);
        check("sat_lap_hold", int'(disp_hold), 0);
        at_max = 1'b0;

        // Saturation from RUNNING
        wait_cycles(25);
        press(3'b001, 2'b01, 1'b0, 1'b0, 22);
        at_max = 1'b1;
        count_ena(15, n_ena, first_ena);
        check("sat_run_no_ena", n_ena, 0);
        check("sat_run_state", int'(state), 2);
        check("sat_run_hold", int'(disp_hold), 0);
        at_max = 1'b0;

        // Bouncing start from IDLE gives exactly one transition
        wait_cycles(25);
        press(3'b100, 2'b00, 1'b0, 1'b1, 23);
        wait_cycles(25);
        changes = 0;
        last_st = state;
        for (int k = 0; k < 50; k++) begin
            btn_start = (k < 20) && ((k % 4) < 2);
            step();
            if (state != last_st) changes++;
            last_st = state;
        end
        btn_start = 1'b0;
        check("bounce_transitions", changes, 1);
        check("bounce_state", int'(state), 1);
        press(3'b001, 2'b10, 1'b0, 1'b0, 24);

        step();
        check("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
